// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone add/subtract, valid/ready at both ends, latency STAGES cycles; stalls ripple back through full stages only.
// Define ADDER_PERF_CNT_EN to add the saturating perf_ops / perf_stall counters.
module pipelined_prefix_adder #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_cin,
    input  logic                  in_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic [TAG_WIDTH-1:0]  out_tag
`ifdef ADDER_PERF_CNT_EN
    ,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_stall
`endif
);

    localparam int W      = DATA_WIDTH;
    localparam int LEVELS = $clog2(DATA_WIDTH);

    // Prefix level already applied when stage k's register is loaded.
    function automatic int lvl_at(input int k);
        int r;
        if (k <= 1 || STAGES < 2) return 0;
        r = ((k - 1) * LEVELS + STAGES - 2) / (STAGES - 1);
        return (r > LEVELS) ? LEVELS : r;
    endfunction

    function automatic int seg_hi(input int k);
        return (k >= STAGES) ? LEVELS : lvl_at(k + 1);
    endfunction

    logic [STAGES:1]      v_q;
    logic [STAGES:1]      ld;
    logic [STAGES:1]      c_q;
    logic [STAGES:1]      m_q;
    logic [W-1:0]         g_q  [1:STAGES];
    logic [W-1:0]         p_q  [1:STAGES];
    logic [W-1:0]         x_q  [1:STAGES];
    logic [TAG_WIDTH-1:0] t_q  [1:STAGES];
    logic [W-1:0]         g_nx [1:STAGES];
    logic [W-1:0]         p_nx [1:STAGES];
    logic [W-1:0]         b_eff;
    logic [W-1:0]         pg_g;
    logic [W-1:0]         pg_p;
    logic [W:0]           carry;
    logic                 ld_acc;

    assign b_eff = in_op ? ~in_b : in_b;

    always_comb begin
        ld         = '0;
        ld_acc     = !v_q[STAGES] || out_ready;
        ld[STAGES] = ld_acc;
        for (int i = STAGES - 1; i >= 1; i--) begin
            ld_acc = !v_q[i] || ld_acc;
            ld[i]  = ld_acc;
        end
    end

    assign in_ready = ld[1];

    // Levels between register k and register k+1 (or the output after the last register).
    always_comb begin
        g_nx = '{default: '0};
        p_nx = '{default: '0};
        pg_g = '0;
        pg_p = '0;
        for (int k = 1; k <= STAGES; k++) begin
            pg_g = g_q[k];
            pg_p = p_q[k];
            for (int l = 1; l <= LEVELS; l++) begin
                if (l > lvl_at(k) && l <= seg_hi(k)) begin
                    for (int i = W - 1; i >= (1 << (l - 1)); i--) begin
                        pg_g[i] = pg_g[i] | (pg_p[i] & pg_g[i - (1 << (l - 1))]);
                        pg_p[i] = pg_p[i] & pg_p[i - (1 << (l - 1))];
                    end
                end
            end
            g_nx[k] = pg_g;
            p_nx[k] = pg_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            m_q <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                g_q[k] <= '0;
                p_q[k] <= '0;
                x_q[k] <= '0;
                t_q[k] <= '0;
            end
        end else begin
            if (ld[1]) begin
                v_q[1] <= in_valid;
                g_q[1] <= in_a & b_eff;
                p_q[1] <= in_a ^ b_eff;
                x_q[1] <= in_a ^ b_eff;
                c_q[1] <= in_cin ^ in_op;
                m_q[1] <= in_a[W-1];
                t_q[1] <= in_tag;
            end
            for (int k = 2; k <= STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_q[k-1];
                    g_q[k] <= g_nx[k-1];
                    p_q[k] <= p_nx[k-1];
                    x_q[k] <= x_q[k-1];
                    c_q[k] <= c_q[k-1];
                    m_q[k] <= m_q[k-1];
                    t_q[k] <= t_q[k-1];
                end
            end
        end
    end

    // Carry into bit i+1 is the full group generate over [i:0], with the carry-in folded in via propagate.
    assign carry     = {g_nx[STAGES] | (p_nx[STAGES] & {W{c_q[STAGES]}}), c_q[STAGES]};
    assign out_valid = v_q[STAGES];
    assign out_sum   = x_q[STAGES] ^ carry[W-1:0];
    assign out_cout  = carry[W];
    assign out_ovf   = !x_q[STAGES][W-1] && (out_sum[W-1] != m_q[STAGES]);
    assign out_tag   = t_q[STAGES];

`ifdef ADDER_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready && perf_ops != 32'hFFFF_FFFF)
                perf_ops <= perf_ops + 32'd1;
            if (out_valid && !out_ready && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench: directed 8-bit/2-stage cases plus random 32-bit streams for STAGES=1..4.
module tb_pipelined_prefix_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic dir_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic op, input logic [3:0] tag);
        longint m, ua, ub, ci, sa, sb, res, val;
        exp_t   e;
        m  = longint'(1) << w;
        ua = longint'({32'd0, a}) & (m - 1);
        ub = longint'({32'd0, b}) & (m - 1);
        ci = cin ? 1 : 0;
        if (!op) begin
            val    = ua + ub + ci;
            e.cout = (val >= m);
            if (val >= m) val = val - m;
        end else begin
            e.cout = (ua >= ub + ci);
            val    = ua - ub - ci;
            if (val < 0) val = val + m;
        end
        sa    = (ua >= m / 2) ? ua - m : ua;
        sb    = (ub >= m / 2) ? ub - m : ub;
        res   = op ? (sa - sb - ci) : (sa + sb + ci);
        e.ovf = (res >= m / 2) || (res < -(m / 2));
        e.sum = val[31:0];
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- directed DUT: DATA_WIDTH=8, STAGES=2 ----------------
    logic       rst8 = 1'b1, iv8 = 1'b0, or8 = 1'b1, cin8 = 1'b0, op8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] tag8 = '0;
    logic       ir8, ov8, cout8, ovf8;
    logic [7:0] sum8;
    logic [3:0] otag8;
`ifdef ADDER_PERF_CNT_EN
    logic [31:0] pops8, pstall8;
`endif
    exp_t q8[$];

    pipelined_prefix_adder #(.DATA_WIDTH(8), .STAGES(2), .TAG_WIDTH(4)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_cin(cin8), .in_op(op8), .in_tag(tag8), .out_valid(ov8), .out_ready(or8),
        .out_sum(sum8), .out_cout(cout8), .out_ovf(ovf8), .out_tag(otag8)
`ifdef ADDER_PERF_CNT_EN
        , .perf_ops(pops8), .perf_stall(pstall8)
`endif
    );

    // Monitor: pops on each output transfer, checks hold during stalls.
    initial begin : mon8
        exp_t        e;
        logic        held;
        logic [13:0] hv;
        held = 1'b0;
        hv   = '0;
        forever begin
            @(negedge clk);
            if (rst8) begin
                held = 1'b0;
            end else begin
                if (held) chk("stall_hold8", 64'({ov8, sum8, cout8, ovf8, otag8}), 64'({1'b1, hv}));
                held = 1'b0;
                if (ov8 && or8) begin
                    if (q8.size() == 0) begin
                        timeout_fail("stray_result8");
                    end else begin
                        e = q8.pop_front();
                        chk("result8", 64'({sum8, cout8, ovf8, otag8}),
                            64'({e.sum[7:0], e.cout, e.ovf, e.tag}));
                    end
                end else if (ov8) begin
                    held = 1'b1;
                    hv   = {sum8, cout8, ovf8, otag8};
                end
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic op, input logic [3:0] tag);
        logic acc;
        acc  = 1'b0;
        iv8  = 1'b1;
        a8   = a;
        b8   = b;
        cin8 = cin;
        op8  = op;
        tag8 = tag;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (ir8) begin
                q8.push_back(model(8, {24'd0, a}, {24'd0, b}, cin, op, tag));
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) timeout_fail("send8");
    endtask

    task automatic run1(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic op, input logic [3:0] tag,
                        input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        send8(a, b, cin, op, tag);
        iv8 = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!ov8 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd1);
        chk(nm, 64'({ov8, sum8, cout8, ovf8, otag8}), 64'({1'b1, es, ec, eo, tag}));
        @(posedge clk);
        #1;
    endtask

    initial begin : directed
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'({ov8, sum8, cout8, ovf8, otag8}), 64'd0);
        chk("reset_in_ready", 64'(ir8), 64'd1);
        @(posedge clk);
        #1;

        run1("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
        run1("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 4'd5, 8'h80, 1'b0, 1'b0 | 1'b1);
        run1("add_cin",  8'h10, 8'h20, 1'b1, 1'b0, 4'd6, 8'h31, 1'b0, 1'b0);
        run1("sub_neg",  8'h05, 8'h07, 1'b0, 1'b1, 4'd7, 8'hFE, 1'b0, 1'b0);
        run1("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 4'd8, 8'h7F, 1'b1, 1'b1);
        run1("sub_bin",  8'h05, 8'h03, 1'b1, 1'b1, 4'd9, 8'h01, 1'b1, 1'b0);

        // Back-pressure: five stalled cycles while streaming tags 0..7.
        or8 = 1'b0;
        send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'd0);
        send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'd1);
        iv8 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("full_in_ready", 64'(ir8), 64'd0);
            @(posedge clk);
            #1;
        end
        or8 = 1'b1;
        for (int t = 2; t < 8; t++)
            send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(t));
        iv8 = 1'b0;
        for (int c = 0; c < 20 && q8.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain8", 64'(q8.size()), 64'd0);

        // Reset with two beats in flight.
        or8 = 1'b0;
        send8(8'h11, 8'h22, 1'b0, 1'b0, 4'hC);
        send8(8'h33, 8'h44, 1'b0, 1'b0, 4'hD);
        iv8  = 1'b0;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("midrst_outputs", 64'({ov8, sum8, cout8, ovf8, otag8}), 64'd0);
        chk("midrst_in_ready", 64'(ir8), 64'd1);
        @(posedge clk);
        #1;
        or8 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        run1("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 4'hA, 8'h46, 1'b0, 1'b0);
`ifdef ADDER_PERF_CNT_EN
        chk("perf_ops8", 64'(pops8), 64'd1);
        chk("perf_stall8", 64'(pstall8), 64'd0);
`endif
        dir_done = 1'b1;
    end

    // ---------------- random DUTs: DATA_WIDTH=32, STAGES=1..4 ----------------
    logic rst_r = 1'b1;

    for (genvar gs = 1; gs <= 4; gs++) begin : g_rand
        logic        iv = 1'b0, ordy = 1'b1, cin = 1'b0, op = 1'b0;
        logic [31:0] a = '0, b = '0;
        logic [3:0]  tag = '0;
        logic        ir, ov, cout, ovf;
        logic [31:0] sum;
        logic [3:0]  otag;
        logic        done = 1'b0, probing = 1'b1;
        int          stalls = 0;
`ifdef ADDER_PERF_CNT_EN
        logic [31:0] pops, pstall;
`endif
        exp_t q[$];

        pipelined_prefix_adder #(.DATA_WIDTH(32), .STAGES(gs), .TAG_WIDTH(4)) dut (
            .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b),
            .in_cin(cin), .in_op(op), .in_tag(tag), .out_valid(ov), .out_ready(ordy),
            .out_sum(sum), .out_cout(cout), .out_ovf(ovf), .out_tag(otag)
`ifdef ADDER_PERF_CNT_EN
            , .perf_ops(pops), .perf_stall(pstall)
`endif
        );

        initial begin : driver
            int   sent, lat;
            logic pend;
            sent = 0;
            pend = 1'b0;
            wait (!rst_r);
            @(posedge clk);
            #1;
            a   = rnd32();
            b   = rnd32();
            cin = 1'($urandom_range(0, 1));
            op  = 1'($urandom_range(0, 1));
            tag = 4'($urandom_range(0, 15));
            iv  = 1'b1;
            @(negedge clk);
            chk($sformatf("probe_ready_s%0d", gs), 64'(ir), 64'd1);
            if (ir) begin
                q.push_back(model(32, a, b, cin, op, tag));
                sent = 1;
            end
            @(posedge clk);
            #1;
            iv  = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!ov && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("latency_s%0d", gs), 64'(lat), 64'(gs - 1));
            probing = 1'b0;
            while (sent < N_RAND) begin
                @(posedge clk);
                #1;
                if (!pend) begin
                    iv  = ($urandom_range(0, 9) < 7);
                    a   = rnd32();
                    b   = rnd32();
                    cin = 1'($urandom_range(0, 1));
                    op  = 1'($urandom_range(0, 1));
                    tag = 4'($urandom_range(0, 15));
                end
                @(negedge clk);
                if (iv && ir) begin
                    q.push_back(model(32, a, b, cin, op, tag));
                    sent++;
                    pend = 1'b0;
                end else begin
                    pend = iv;
                end
            end
            @(posedge clk);
            #1;
            iv = 1'b0;
        end

        initial begin : ready_gen
            wait (!probing);
            while (!done) begin
                @(posedge clk);
                #1;
                ordy = ($urandom_range(0, 3) != 0);
            end
        end

        initial begin : monitor
            exp_t e;
            int   rcvd, cyc;
            rcvd = 0;
            cyc  = 0;
            wait (!rst_r);
            while (rcvd < N_RAND && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                if (ov && !ordy) stalls++;
                if (ov && ordy) begin
                    if (q.size() == 0) begin
                        timeout_fail($sformatf("stray_result_s%0d", gs));
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rand_s%0d", gs), 64'({sum, cout, ovf, otag}),
                            64'({e.sum, e.cout, e.ovf, e.tag}));
                    end
                    rcvd++;
                end
            end
            if (rcvd < N_RAND) timeout_fail($sformatf("rand_drain_s%0d", gs));
`ifdef ADDER_PERF_CNT_EN
            @(posedge clk);
            #1;
            chk($sformatf("perf_ops_s%0d", gs), 64'(pops), 64'(N_RAND));
            chk($sformatf("perf_stall_s%0d", gs), 64'(pstall), 64'(stalls));
`endif
            done = 1'b1;
        end
    end

    initial begin : main
        logic all_done;
        repeat (4) @(posedge clk);
        #1;
        rst_r    = 1'b0;
        all_done = 1'b0;
        for (int c = 0; c < 70000 && !all_done; c++) begin
            @(posedge clk);
            all_done = dir_done && g_rand[1].done && g_rand[2].done &&
                       g_rand[3].done && g_rand[4].done;
        end
        if (!all_done) timeout_fail("global_watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
Parametrised, pipelined Kogge-Stone parallel-prefix add/subtract unit with valid/ready handshakes at both ends, for the adder IP.
- Generalises the combinational prefix adder with configurable pipeline depth, add/sub mode, signed-overflow flag and a sideband tag.
- Sits between an upstream operand source and a downstream result consumer.
- Full throughput (one operation per cycle) when not back-pressured.

Parameters:
DATA_WIDTH, 32, operand width in bits; minimum 2.
STAGES, 2, number of pipeline register stages; range 1..LEVELS+1, where LEVELS = clog2(DATA_WIDTH). Latency is STAGES cycles.
TAG_WIDTH, 4, width of the sideband tag carried alongside each operation; minimum 1.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
in_a  in  DATA_WIDTH  operand A.
in_b  in  DATA_WIDTH  operand B.
in_cin  in  1  carry-in; borrow-in when subtracting.
in_op  in  1  0 = add, 1 = subtract.
in_tag  in  TAG_WIDTH  sideband tag, returned unchanged with the result.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result this cycle.
out_sum  out  DATA_WIDTH  result bits.
out_cout  out  1  carry-out; for subtract, 1 = no borrow.
out_ovf  out  1  two's-complement signed overflow.
out_tag  out  TAG_WIDTH  tag of this result.

Behaviour:
- Arithmetic:
  - b_eff = in_op ? ~in_b : in_b; c_eff = in_cin ^ in_op.
  - {out_cout, out_sum} = in_a + b_eff + c_eff, computed with a DATA_WIDTH+1-bit result.
  - Examples: subtract with in_cin=0 gives a-b; subtract with in_cin=1 gives a-b-1.
  - out_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Prefix tree: Kogge-Stone, LEVELS levels, span 2^(level-1).
  - Stage 1 register captures the operands plus the p/g terms.
  - Each remaining register j (j = 1..STAGES-1) sits after prefix level ceil(j*LEVELS/(STAGES-1)), capped at LEVELS.
  - Final sum XOR and flags are combinational from the last register; outputs are not re-registered.
- Per-stage valid bit v[i], i = 1..STAGES. Stage STAGES drives the out_* ports.
- Stage load rule:
  - ld[STAGES] = !v[STAGES] || out_ready.
  - ld[i] = !v[i] || ld[i+1].
  - in_ready = ld[1].
  - When ld[i] is high, stage i captures stage i-1 data and v[i] <= v[i-1]; for stage 1, v[1] <= in_valid.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready may depend combinationally on out_ready.
  - out_valid must not depend on out_ready.
- Bubbles collapse: an empty stage always loads, even while downstream is stalled.
- While out_valid && !out_ready: all out_* held stable, no result dropped or duplicated.
- Ordering: results leave strictly in acceptance order; each tag stays bound to its own result.
- Latency with out_ready held high: a beat accepted at edge N gives out_valid high after edge N+STAGES-1.
- Simultaneous accept and emit on a full pipeline: sustained, no bubble.
- Reset:
  - All v[i] <= 0; all data registers <= 0.
  - After reset, out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_tag = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight beat, with no output for them.
- Wrap-around: the sum is modulo 2^DATA_WIDTH; the carry appears only on out_cout.

Optional Feature:
Macro: ADDER_PERF_CNT_EN.
- Defined:
  - Adds output perf_ops (32 bits): count of output transfers.
  - Adds output perf_stall (32 bits): count of cycles with out_valid && !out_ready.
  - Both counters saturate at 0xFFFFFFFF and clear to 0 on rst.
- Undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Test Plan:
All scenarios use DATA_WIDTH=8, STAGES=2 with out_ready=1 unless stated.
1. Add, a=0xFF, b=0x01, cin=0, tag=3 -> two cycles later: sum=0x00, cout=1, ovf=0, tag=3.
2. Add, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Add, a=0x10, b=0x20, cin=1 -> sum=0x31, cout=0, ovf=0.
3. Subtract, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0. Subtract, a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1.
4. Back-pressure: stream tags 0..7 back-to-back while holding out_ready=0 for 5 cycles.
   - in_ready drops once both stages are full.
   - Outputs stay stable during the stall.
   - After release, all 8 results arrive in order, exactly once.
5. Reset mid-stream: assert rst for 1 cycle with 2 beats in flight.
   - out_valid=0 with all outputs 0 next cycle; in_ready=1.
   - No stale result ever appears.
6. Sweep STAGES=1..4 with DATA_WIDTH=32 and 10k random beats against a reference model, with random in_valid/out_ready.
   - All results match.
   - Measured latency equals STAGES.
   - With ADDER_PERF_CNT_EN defined, perf_ops = 10000 and perf_stall equals the bench-counted stall cycles.
